// File: rtl/usb_line_ctrl_seq_pkg.sv
// usb_line_ctrl_seq_pkg: shared USB SIE encodings and line-state helpers
package usb_line_ctrl_seq_pkg;
    typedef enum logic [1:0] {
        CMD_RESET  = 2'b00,
        CMD_RESUME = 2'b01,
        CMD_EOP    = 2'b10,
        CMD_RSVD   = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRV_SE0 = 3'd1,
        DRV_K   = 3'd2,
        EOP_SE0 = 3'd3,
        EOP_J   = 3'd4,
        DONE    = 3'd5
    } state_e;

    localparam logic [1:0] SE0 = 2'b00;

    function automatic logic [1:0] j_of(input logic pol);
        return pol ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [1:0] k_of(input logic pol);
        return pol ? 2'b01 : 2'b10;
    endfunction

    // {oe, line}: active states use the command polarity, idle states track the live input
    function automatic logic [2:0] drive(input state_e s, input logic pol, input logic live);
        return (s == DRV_SE0 || s == EOP_SE0) ? {1'b1, SE0} :
               (s == DRV_K)                   ? {1'b1, k_of(pol)} :
               (s == EOP_J)                   ? {1'b1, j_of(pol)} :
                                                {1'b0, j_of(live)};
    endfunction
endpackage

// File: rtl/usb_line_ctrl_seq_if.sv
// usb_line_ctrl_seq_if: command handshake and line drive bundle
interface usb_line_ctrl_seq_if;
    logic        fullSpeedPolarity;
    logic        fullSpeedBitRate;
    logic        cmdReq;
    logic [1:0]  cmdCode;
    logic [15:0] cmdLen;
    logic        cmdAck;
    logic        cmdBusy;
    logic [1:0]  lineOut;
    logic        lineOE;

    modport master (
        output fullSpeedPolarity, fullSpeedBitRate, cmdReq, cmdCode, cmdLen,
        input  cmdAck, cmdBusy, lineOut, lineOE
    );

    modport slave (
        input  fullSpeedPolarity, fullSpeedBitRate, cmdReq, cmdCode, cmdLen,
        output cmdAck, cmdBusy, lineOut, lineOE
    );
endinterface

// File: rtl/usb_bit_tick.sv
// usb_bit_tick: restartable divider producing one tick per bit time
module usb_bit_tick #(
    parameter int CLK_PER_FS_BIT = 4,
    parameter int CLK_PER_LS_BIT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic fs,
    output logic tick
);
    localparam int MAXDIV = (CLK_PER_LS_BIT > CLK_PER_FS_BIT) ? CLK_PER_LS_BIT : CLK_PER_FS_BIT;
    localparam int W = $clog2(MAXDIV + 1);

    logic [W-1:0] cnt;
    logic [W-1:0] div;

    assign div  = fs ? W'(CLK_PER_FS_BIT - 1) : W'(CLK_PER_LS_BIT - 1);
    assign tick = (cnt == div) && !restart;

    always_ff @(posedge clk)
        if (!rst_n || restart || tick) cnt <= '0;
        else cnt <= cnt + W'(1);
endmodule

// File: rtl/usb_line_ctrl_seq.sv
// usb_line_ctrl_seq: sequences USB reset, resume and EOP line states
module usb_line_ctrl_seq
    import usb_line_ctrl_seq_pkg::*;
#(
    parameter int CLK_PER_FS_BIT = 4,
    parameter int CLK_PER_LS_BIT = 32
) (
    input logic               clk,
    input logic               rst_n,
    usb_line_ctrl_seq_if.slave bus
);
    state_e      state, nxt;
    logic [15:0] len_q, bits, target;
    logic        pol_q, fs_q, tick, last, ack, busy, oe;
    logic [1:0]  line;

    usb_bit_tick #(.CLK_PER_FS_BIT(CLK_PER_FS_BIT), .CLK_PER_LS_BIT(CLK_PER_LS_BIT)) u_tick (
        .clk(clk),
        .rst_n(rst_n),
        .restart(state == IDLE || state == DONE),
        .fs(fs_q),
        .tick(tick)
    );

    // bits never exceeds target-1, so the 16-bit count cannot wrap
    assign target = (state == EOP_SE0) ? 16'd2 : (state == EOP_J) ? 16'd1 : len_q;
    assign last   = tick && (bits == target - 16'd1);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = !bus.cmdReq ? IDLE :
                           (cmd_e'(bus.cmdCode) == CMD_RESET)  ? DRV_SE0 :
                           (cmd_e'(bus.cmdCode) == CMD_RESUME) ? DRV_K :
                           (cmd_e'(bus.cmdCode) == CMD_EOP)    ? EOP_SE0 : DONE;
            DRV_SE0: nxt = last ? DONE : DRV_SE0;
            DRV_K:   nxt = last ? EOP_SE0 : DRV_K;
            EOP_SE0: nxt = last ? EOP_J : EOP_SE0;
            EOP_J:   nxt = last ? DONE : EOP_J;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            bits  <= '0;
            len_q <= 16'd1;
            pol_q <= 1'b0;
            fs_q  <= 1'b0;
            ack   <= 1'b0;
            busy  <= 1'b0;
            oe    <= 1'b0;
            line  <= j_of(bus.fullSpeedPolarity);
        end else begin
            state      <= nxt;
            bits       <= (nxt != state) ? '0 : bits + 16'(tick);
            ack        <= nxt == DONE;
            busy       <= nxt != IDLE;
            {oe, line} <= drive(nxt, (state == IDLE) ? bus.fullSpeedPolarity : pol_q, bus.fullSpeedPolarity);
            if (state == IDLE && bus.cmdReq) begin
                len_q <= (bus.cmdLen == 16'd0) ? 16'd1 : bus.cmdLen;
                pol_q <= bus.fullSpeedPolarity;
                fs_q  <= bus.fullSpeedBitRate;
            end
        end
    end

    assign bus.cmdAck  = ack;
    assign bus.cmdBusy = busy;
    assign bus.lineOut = line;
    assign bus.lineOE  = oe;
endmodule

// File: doc/usb_line_ctrl_seq.md
USB_LINE_CTRL_SEQ -- requirements
Module: usb_line_ctrl_seq

Interface
REQ-001 SHALL provide parameter CLK_PER_FS_BIT, default 4, meaning clocks per full-speed bit time (48 MHz / 12 Mb/s).
REQ-002 SHALL provide parameter CLK_PER_LS_BIT, default 32, meaning clocks per low-speed bit time (48 MHz / 1.5 Mb/s).
REQ-003 SHALL have port clk, input, 1 bit, single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-005 SHALL have port fullSpeedPolarity, input, 1 bit: 1 means J={D+,D-}=2'b10 and K=2'b01; 0 means J=2'b01 and K=2'b10.
REQ-006 SHALL have port fullSpeedBitRate, input, 1 bit: 1 selects CLK_PER_FS_BIT and 0 selects CLK_PER_LS_BIT.
REQ-007 SHALL have port cmdReq, input, 1 bit, command request (level).
REQ-008 SHALL have port cmdCode, input, 2 bits: 00 USB reset, 01 resume, 10 EOP, 11 reserved.
REQ-009 SHALL have port cmdLen, input, 16 bits, duration in bit times for reset or resume.
REQ-010 SHALL have port cmdAck, output, 1 bit, one-cycle completion pulse.
REQ-011 SHALL have port cmdBusy, output, 1 bit, high while state is not IDLE.
REQ-012 SHALL have port lineOut, output, 2 bits, driven {D+,D-}.
REQ-013 SHALL have port lineOE, output, 1 bit, transceiver output enable.

Function
REQ-014 SHALL accept a command on a clk edge where cmdReq=1 and state=IDLE.
REQ-015 SHALL latch cmdCode, cmdLen (0 treated as 1), polarity and bit rate at acceptance; later input changes SHALL NOT affect the active command.
REQ-016 SHALL use the states IDLE, DRV_SE0, DRV_K, EOP_SE0, EOP_J and DONE.
REQ-017 SHALL transition from IDLE on acceptance by code: 00 to DRV_SE0, 01 to DRV_K, 10 to EOP_SE0, 11 to DONE.
REQ-018 SHALL keep DRV_SE0 for cmdLen bit times, then go to DONE.
REQ-019 SHALL keep DRV_K for cmdLen bit times, then go to EOP_SE0.
REQ-020 SHALL keep EOP_SE0 for 2 bit times, then go to EOP_J.
REQ-021 SHALL keep EOP_J for 1 bit time, then go to DONE.
REQ-022 SHALL leave DONE for IDLE after exactly 1 cycle.
REQ-023 SHALL register lineOut and lineOE, reflecting the current state in the same cycle that state is entered.
REQ-024 SHALL drive lineOut=00 and lineOE=1 in DRV_SE0 and EOP_SE0.
REQ-025 SHALL drive lineOut=K and lineOE=1 in DRV_K.
REQ-026 SHALL drive lineOut=J and lineOE=1 in EOP_J.
REQ-027 SHALL drive lineOut=J (from the live polarity input) and lineOE=0 in IDLE and DONE.
REQ-028 SHALL assert cmdAck only in DONE.
REQ-029 SHALL ignore cmdReq in every state except IDLE; the requester drops cmdReq in the cycle after it samples cmdAck=1.
REQ-030 SHALL use a bit-time counter that restarts at each state entry; 16-bit bit-count arithmetic SHALL NOT wrap, so cmdLen=65535 gives exactly 65535 bit times.

Reset
REQ-031 SHALL, when rst_n=0 at a clk edge, set state=IDLE, cmdAck=0, cmdBusy=0, lineOE=0 and lineOut=J of the current polarity, and clear all counters.
REQ-032 SHALL abort any in-progress command on reset with no cmdAck.

Structure
REQ-033 SHALL place the command encodings (CMD_RESET, CMD_RESUME, CMD_EOP, CMD_RSVD), the state encodings and the SE0 constant 2'b00 in the shared USB SIE package.
REQ-034 SHALL instantiate one sub-module, usb_bit_tick, a restartable divider that emits a one-cycle tick every CLK_PER_FS_BIT or CLK_PER_LS_BIT clocks according to the latched rate.

Verification
REQ-035 SHALL test: FS, polarity 1, EOP command -> lineOut=00 for 8 clocks, then 10 for 4 clocks, then cmdAck for 1 cycle with lineOE=0.
REQ-036 SHALL test: FS, polarity 0, resume with cmdLen=3 -> lineOut=10 for 12 clocks, 00 for 8 clocks, 01 for 4 clocks, then cmdAck.
REQ-037 SHALL test: LS, USB reset with cmdLen=0 -> SE0 for 32 clocks, then cmdAck.
REQ-038 SHALL test: reserved code 11 -> cmdAck in the second cycle after acceptance with lineOE never asserted.
REQ-039 SHALL test: rst_n low for 1 cycle mid-DRV_K -> IDLE the next cycle, lineOE=0, and no cmdAck.
REQ-040 SHALL test: polarity and rate toggled mid-command, and cmdReq asserted while busy -> the active waveform is unchanged and the second request is accepted only after DONE.
